tx_phy_serializer: RTL and testbench

Byte serializer between the TCPC transmit block and the PD PHY. It latches the 240-bit message image produced by the transmitter (header plus up to seven data objects) and streams it to the PHY one byte per valid/ready handshake. Optionally it appends a CRC-32. It reports completion through `MessageSentToPhy`, which feeds the transmitter's retry/GoodCRC logic.

---
 rtl/tx_phy_serializer.sv | 161 ++++++++++++++++
 tb/tb_tx_phy_serializer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_phy_serializer.sv
// rtl/tx_phy_serializer.sv - TCPC-to-PHY byte serializer; optional CRC-32 append under TX_CRC_APPEND_EN
module tx_phy_serializer #(
  parameter int MAX_BYTES = 30
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [MAX_BYTES*8-1:0] TRANSMIT_DATA_OUTPUT,
  input  logic                   START,
  input  logic [4:0]             BYTE_COUNT,
  input  logic                   DISCARD,
  output logic [7:0]             PHY_TX_DATA,
  output logic                   PHY_TX_VALID,
  input  logic                   PHY_TX_READY,
  output logic                   PHY_TX_SOP,
  output logic                   PHY_TX_EOP,
  output logic                   MessageSentToPhy,
  output logic                   MessageDiscarded,
  output logic                   BUSY
);

  localparam int          W       = MAX_BYTES * 8;
  localparam logic [5:0]  MAX_CNT = 6'(MAX_BYTES);

`ifdef TX_CRC_APPEND_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND_DATA = 2'd1, SEND_CRC = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND_DATA = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t         state_q, state_d;
  logic [W-1:0]   shreg_q;
  logic [4:0]     cnt_q;
  logic [5:0]     idx_q;
  logic           disc_q;
  logic           len_ok;
  logic           hs;
  logic [5:0]     last_idx;

  assign len_ok   = (BYTE_COUNT >= 5'd2) && ({1'b0, BYTE_COUNT} <= MAX_CNT);
  assign last_idx = {1'b0, cnt_q} - 6'd1;
  assign hs       = PHY_TX_VALID & PHY_TX_READY;
  assign BUSY     = (state_q != IDLE);
  assign MessageDiscarded = disc_q;

`ifdef TX_CRC_APPEND_EN
  logic [31:0] crc_q;
  logic [31:0] crc_nxt;
  logic [5:0]  crc_last;

  // Bytewise reflected CRC-32 step, LSB of the byte folded in first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_nxt  = crc32_byte(crc_q, shreg_q[7:0]);
  assign crc_last = {1'b0, cnt_q} + 6'd3;
`endif

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and stream outputs; the byte on the wire is always the low byte of the shift register.
  always_comb begin
    state_d          = state_q;
    PHY_TX_VALID     = 1'b0;
    PHY_TX_DATA      = 8'h00;
    PHY_TX_SOP       = 1'b0;
    PHY_TX_EOP       = 1'b0;
    MessageSentToPhy = 1'b0;
    case (state_q)
      IDLE: begin
        if (!DISCARD && START && len_ok) state_d = SEND_DATA;
      end
      SEND_DATA: begin
        PHY_TX_VALID = 1'b1;
        PHY_TX_DATA  = shreg_q[7:0];
        PHY_TX_SOP   = (idx_q == 6'd0);
`ifndef TX_CRC_APPEND_EN
        PHY_TX_EOP   = (idx_q == last_idx);
`endif
        if (DISCARD) begin
          state_d = IDLE;
        end else if (PHY_TX_READY && (idx_q == last_idx)) begin
`ifdef TX_CRC_APPEND_EN
          state_d = SEND_CRC;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef TX_CRC_APPEND_EN
      SEND_CRC: begin
        PHY_TX_VALID = 1'b1;
        PHY_TX_DATA  = shreg_q[7:0];
        PHY_TX_EOP   = (idx_q == crc_last);
        if (DISCARD)                                   state_d = IDLE;
        else if (PHY_TX_READY && (idx_q == crc_last))  state_d = DONE;
      end
`endif
      DONE: begin
        MessageSentToPhy = ~DISCARD;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accepted START, advance on handshake, flag aborts and bad lengths for one cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      shreg_q <= '0;
      cnt_q   <= 5'd0;
      idx_q   <= 6'd0;
      disc_q  <= 1'b0;
`ifdef TX_CRC_APPEND_EN
      crc_q   <= 32'hFFFFFFFF;
`endif
    end else begin
      disc_q <= 1'b0;
      if (state_q == IDLE) begin
        if (START && !DISCARD) begin
          if (len_ok) begin
            shreg_q <= TRANSMIT_DATA_OUTPUT;
            cnt_q   <= BYTE_COUNT;
            idx_q   <= 6'd0;
`ifdef TX_CRC_APPEND_EN
            crc_q   <= 32'hFFFFFFFF;
`endif
          end else begin
            disc_q <= 1'b1;
          end
        end
      end else if (DISCARD) begin
        disc_q <= 1'b1;
      end else if (hs) begin
        idx_q <= idx_q + 6'd1;
`ifdef TX_CRC_APPEND_EN
        if (state_q == SEND_DATA) begin
          crc_q <= crc_nxt;
          // After the last data byte the shift register carries the inverted CRC, LSB first.
          if (idx_q == last_idx) shreg_q <= {{(W-32){1'b0}}, ~crc_nxt};
          else                   shreg_q <= {8'h00, shreg_q[W-1:8]};
        end else begin
          shreg_q <= {8'h00, shreg_q[W-1:8]};
        end
`else
        shreg_q <= {8'h00, shreg_q[W-1:8]};
`endif
      end
    end
  end

endmodule

// File: tb/tb_tx_phy_serializer.sv
// tb/tb_tx_phy_serializer.sv - self-checking bench for tx_phy_serializer
module tb_tx_phy_serializer;

  logic         Clock;
  logic         Reset;
  logic [239:0] TRANSMIT_DATA_OUTPUT;
  logic         START;
  logic [4:0]   BYTE_COUNT;
  logic         DISCARD;
  logic [7:0]   PHY_TX_DATA;
  logic         PHY_TX_VALID;
  logic         PHY_TX_READY;
  logic         PHY_TX_SOP;
  logic         PHY_TX_EOP;
  logic         MessageSentToPhy;
  logic         MessageDiscarded;
  logic         BUSY;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  tx_phy_serializer #(.MAX_BYTES(30)) dut (
    .Clock(Clock), .Reset(Reset),
    .TRANSMIT_DATA_OUTPUT(TRANSMIT_DATA_OUTPUT),
    .START(START), .BYTE_COUNT(BYTE_COUNT), .DISCARD(DISCARD),
    .PHY_TX_DATA(PHY_TX_DATA), .PHY_TX_VALID(PHY_TX_VALID), .PHY_TX_READY(PHY_TX_READY),
    .PHY_TX_SOP(PHY_TX_SOP), .PHY_TX_EOP(PHY_TX_EOP),
    .MessageSentToPhy(MessageSentToPhy), .MessageDiscarded(MessageDiscarded), .BUSY(BUSY)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference CRC: bit-serial over the whole message, LSB of each byte first, final inversion applied.
  function automatic logic [31:0] ref_crc(input logic [239:0] img, input int n);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    for (int b = 0; b < 8 * n; b++) begin
      fb = c[0] ^ img[b];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return ~c;
  endfunction

  // Expected wire bytes: message bytes in order, then the CRC bytes when appended.
  task automatic build_expected(input logic [239:0] img, input int n);
    logic [31:0] r;
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(img[8*k +: 8]);
`ifdef TX_CRC_APPEND_EN
    r = ref_crc(img, n);
    for (int i = 0; i < 4; i++) exp_q.push_back(r[8*i +: 8]);
`else
    r = 32'h0;
`endif
  endtask

  function automatic logic [239:0] rand_img();
    logic [239:0] v;
    for (int k = 0; k < 30; k++) v[8*k +: 8] = 8'($urandom);
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the first IDLE cycle after completion.
  // mode: 0 ready high, 1 ready toggling 1-0-1-0, 2 random ready.
  task automatic send_and_check(input string name, input logic [239:0] img, input logic [4:0] cnt, input int mode);
    int nexp, hs, cyc;
    bit fin, held;
    logic [7:0] hd;
    logic hsop, heop;
    nexp = exp_q.size(); hs = 0; cyc = 0; fin = 0; held = 0; hd = 8'h00; hsop = 0; heop = 0;
    TRANSMIT_DATA_OUTPUT = img; BYTE_COUNT = cnt; START = 1'b1; PHY_TX_READY = 1'b0;
    @(posedge Clock); #1;
    START = 1'b0;
    while (!fin && cyc < 400) begin
      cyc++;
      if (mode == 0)      PHY_TX_READY = 1'b1;
      else if (mode == 1) PHY_TX_READY = cyc[0];
      else                PHY_TX_READY = 1'($urandom_range(0, 1));
      @(negedge Clock);
      if (held) begin
        tests++;
        if ({PHY_TX_DATA, PHY_TX_SOP, PHY_TX_EOP} !== {hd, hsop, heop}) begin
          fails++;
          $display("FAIL %s hold: got %h/%b/%b required %h/%b/%b", name, PHY_TX_DATA, PHY_TX_SOP, PHY_TX_EOP, hd, hsop, heop);
        end
      end
      if (hs < nexp) begin
        tests++;
        if (PHY_TX_VALID !== 1'b1 || MessageSentToPhy !== 1'b0 || MessageDiscarded !== 1'b0) begin
          fails++;
          $display("FAIL %s valid at byte %0d: got valid=%b sent=%b disc=%b required 1/0/0", name, hs, PHY_TX_VALID, MessageSentToPhy, MessageDiscarded);
          fin = 1;
        end else if (PHY_TX_READY) begin
          tests++;
          if (PHY_TX_DATA !== exp_q[hs] || PHY_TX_SOP !== (hs == 0) || PHY_TX_EOP !== (hs == nexp - 1)) begin
            fails++;
            $display("FAIL %s byte %0d: got %h sop=%b eop=%b required %h sop=%b eop=%b", name, hs, PHY_TX_DATA, PHY_TX_SOP, PHY_TX_EOP, exp_q[hs], hs == 0, hs == nexp - 1);
          end
          hs++;
          held = 0;
        end else begin
          held = 1; hd = PHY_TX_DATA; hsop = PHY_TX_SOP; heop = PHY_TX_EOP;
        end
      end else begin
        tests++;
        if (MessageSentToPhy !== 1'b1 || PHY_TX_VALID !== 1'b0 || BUSY !== 1'b1) begin
          fails++;
          $display("FAIL %s done: got sent=%b valid=%b busy=%b required 1/0/1", name, MessageSentToPhy, PHY_TX_VALID, BUSY);
        end
        if (mode == 0) begin
          tests++;
          if (cyc !== nexp + 1) begin
            fails++;
            $display("FAIL %s pulse cycle: got %0d required %0d", name, cyc, nexp + 1);
          end
        end
        fin = 1;
      end
      @(posedge Clock); #1;
    end
    PHY_TX_READY = 1'b0;
    tests++;
    if (hs !== nexp) begin
      fails++;
      $display("FAIL %s handshakes: got %0d required %0d", name, hs, nexp);
    end
    tests++;
    if (BUSY !== 1'b0 || MessageSentToPhy !== 1'b0 || MessageDiscarded !== 1'b0) begin
      fails++;
      $display("FAIL %s idle after done: got busy=%b sent=%b disc=%b required 0/0/0", name, BUSY, MessageSentToPhy, MessageDiscarded);
    end
  endtask

  task automatic check_all_zero(input string name);
    tests++;
    if ({PHY_TX_DATA, PHY_TX_VALID, PHY_TX_SOP, PHY_TX_EOP, MessageSentToPhy, MessageDiscarded, BUSY} !== 14'h0) begin
      fails++;
      $display("FAIL %s: got data=%h valid=%b sop=%b eop=%b sent=%b disc=%b busy=%b required all 0", name,
               PHY_TX_DATA, PHY_TX_VALID, PHY_TX_SOP, PHY_TX_EOP, MessageSentToPhy, MessageDiscarded, BUSY);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; START = 1'b0; DISCARD = 1'b0; PHY_TX_READY = 1'b0;
    BYTE_COUNT = 5'd0; TRANSMIT_DATA_OUTPUT = '0;
    repeat (3) @(posedge Clock);
    #1;
    check_all_zero("reset_state");
    Reset = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_directed();
    logic [239:0] img;
    img = '0;
`ifdef TX_CRC_APPEND_EN
    for (int k = 0; k < 9; k++) img[8*k +: 8] = 8'h31 + 8'(k);
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    send_and_check("crc_vector", img, 5'd9, 0);
`else
    img[15:0] = 16'h7B7B;
    exp_q = '{8'h7B, 8'h7B};
    send_and_check("two_byte", img, 5'd2, 0);
`endif
  endtask

  task automatic test_long_toggle();
    logic [239:0] img;
    img = rand_img();
    build_expected(img, 30);
    send_and_check("long_toggle", img, 5'd30, 1);
  endtask

  task automatic test_random();
    logic [239:0] img;
    int n;
    for (int t = 0; t < 6; t++) begin
      img = rand_img();
      n = $urandom_range(2, 30);
      build_expected(img, n);
      send_and_check("random", img, 5'(n), 2);
      repeat ($urandom_range(0, 3)) @(posedge Clock);
      #0;
    end
  endtask

  task automatic test_back_to_back();
    logic [239:0] img;
    int n;
    for (int t = 0; t < 4; t++) begin
      img = rand_img();
      n = $urandom_range(2, 30);
      build_expected(img, n);
      send_and_check("back_to_back", img, 5'(n), 0);
    end
  endtask

  task automatic test_discard_mid();
    logic [239:0] img;
    img = rand_img();
    build_expected(img, 10);
    TRANSMIT_DATA_OUTPUT = img; BYTE_COUNT = 5'd10; START = 1'b1; PHY_TX_READY = 1'b1;
    @(posedge Clock); #1;
    START = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin PHY_TX_READY = 1'b0; DISCARD = 1'b1; end
      @(negedge Clock);
      tests++;
      if (PHY_TX_VALID !== 1'b1 || PHY_TX_DATA !== exp_q[c] || MessageSentToPhy !== 1'b0) begin
        fails++;
        $display("FAIL discard_pre byte %0d: got valid=%b data=%h sent=%b required 1/%h/0", c, PHY_TX_VALID, PHY_TX_DATA, MessageSentToPhy, exp_q[c]);
      end
      @(posedge Clock); #1;
    end
    DISCARD = 1'b0;
    @(negedge Clock);
    tests++;
    if (PHY_TX_VALID !== 1'b0 || MessageDiscarded !== 1'b1 || BUSY !== 1'b0 || MessageSentToPhy !== 1'b0) begin
      fails++;
      $display("FAIL discard_mid: got valid=%b disc=%b busy=%b sent=%b required 0/1/0/0", PHY_TX_VALID, MessageDiscarded, BUSY, MessageSentToPhy);
    end
    @(posedge Clock); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      tests++;
      if (MessageDiscarded !== 1'b0 || MessageSentToPhy !== 1'b0 || PHY_TX_VALID !== 1'b0) begin
        fails++;
        $display("FAIL discard_after: got disc=%b sent=%b valid=%b required 0/0/0", MessageDiscarded, MessageSentToPhy, PHY_TX_VALID);
      end
      @(posedge Clock); #1;
    end
    img = rand_img();
    build_expected(img, 7);
    send_and_check("after_discard", img, 5'd7, 0);
  endtask

  task automatic test_discard_done();
    logic [239:0] img;
    int n;
    img = rand_img();
    build_expected(img, 2);
    n = exp_q.size();
    TRANSMIT_DATA_OUTPUT = img; BYTE_COUNT = 5'd2; START = 1'b1; PHY_TX_READY = 1'b1;
    @(posedge Clock); #1;
    START = 1'b0;
    repeat (n) @(posedge Clock);
    #1;
    DISCARD = 1'b1;
    @(negedge Clock);
    tests++;
    if (MessageSentToPhy !== 1'b0 || BUSY !== 1'b1 || PHY_TX_VALID !== 1'b0) begin
      fails++;
      $display("FAIL discard_done: got sent=%b busy=%b valid=%b required 0/1/0", MessageSentToPhy, BUSY, PHY_TX_VALID);
    end
    @(posedge Clock); #1;
    DISCARD = 1'b0; PHY_TX_READY = 1'b0;
    @(negedge Clock);
    tests++;
    if (MessageDiscarded !== 1'b1 || BUSY !== 1'b0 || MessageSentToPhy !== 1'b0) begin
      fails++;
      $display("FAIL discard_done_next: got disc=%b busy=%b sent=%b required 1/0/0", MessageDiscarded, BUSY, MessageSentToPhy);
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_illegal(input logic [4:0] cnt);
    int pulses;
    bit bad;
    pulses = 0; bad = 0;
    TRANSMIT_DATA_OUTPUT = rand_img(); BYTE_COUNT = cnt; START = 1'b1; PHY_TX_READY = 1'b1;
    @(posedge Clock); #1;
    START = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clock);
      if (MessageDiscarded === 1'b1) pulses++;
      if (c == 1) begin
        tests++;
        if (MessageDiscarded !== 1'b1) begin
          fails++;
          $display("FAIL illegal_%0d pulse: got %b required 1", cnt, MessageDiscarded);
        end
      end
      if (PHY_TX_VALID !== 1'b0 || BUSY !== 1'b0 || MessageSentToPhy !== 1'b0) bad = 1;
      @(posedge Clock); #1;
    end
    PHY_TX_READY = 1'b0;
    tests++;
    if (pulses !== 1 || bad) begin
      fails++;
      $display("FAIL illegal_%0d: got pulses=%0d activity=%b required 1/0", cnt, pulses, bad);
    end
  endtask

  task automatic test_discard_start_idle();
    bit bad;
    bad = 0;
    TRANSMIT_DATA_OUTPUT = rand_img(); BYTE_COUNT = 5'd5; START = 1'b1; DISCARD = 1'b1; PHY_TX_READY = 1'b1;
    @(posedge Clock); #1;
    START = 1'b0; DISCARD = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      if (PHY_TX_VALID !== 1'b0 || MessageDiscarded !== 1'b0 || BUSY !== 1'b0) bad = 1;
      @(posedge Clock); #1;
    end
    PHY_TX_READY = 1'b0;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL discard_start_idle: got activity=1 required 0");
    end
  endtask

  task automatic test_reset_mid();
    logic [239:0] img;
    bit bad;
    bad = 0;
    img = rand_img();
    TRANSMIT_DATA_OUTPUT = img; BYTE_COUNT = 5'd30; START = 1'b1; PHY_TX_READY = 1'b1;
    @(posedge Clock); #1;
    START = 1'b0;
    repeat (5) @(posedge Clock);
    #1;
    tests++;
    if (PHY_TX_VALID !== 1'b1 || PHY_TX_DATA !== img[47:40]) begin
      fails++;
      $display("FAIL reset_mid_pre: got valid=%b data=%h required 1/%h", PHY_TX_VALID, PHY_TX_DATA, img[47:40]);
    end
    Reset = 1'b0;
    #1;
    check_all_zero("reset_mid");
    @(posedge Clock); #1;
    Reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clock);
      if (MessageSentToPhy !== 1'b0 || MessageDiscarded !== 1'b0 || PHY_TX_VALID !== 1'b0) bad = 1;
      @(posedge Clock); #1;
    end
    PHY_TX_READY = 1'b0;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL reset_after: got activity=1 required 0");
    end
    img = rand_img();
    build_expected(img, 12);
    send_and_check("after_reset", img, 5'd12, 2);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_long_toggle();
    test_random();
    test_back_to_back();
    test_discard_mid();
    test_discard_done();
    test_illegal(5'd1);
    test_illegal(5'd31);
    test_illegal(5'd0);
    test_discard_start_idle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
